// File: rtl/result_uart_reporter.sv
// Sends the captured 32-bit core result once over UART as "0xHHHHHHHH\r\n" and blinks an LED when finished.
// Optional build macro REPORTER_PARITY_EN switches framing from 8N1 to 8E1.
module result_uart_reporter #(
  parameter int CLKS_PER_BIT   = 217,
  parameter int BLINK_DIV_BITS = 24
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_finished,
  input  logic [31:0] i_result,
  output logic        o_uart_tx,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_led
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        LAST_BYTE = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef REPORTER_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  state_t                    state, state_nxt;
  logic                      fin_q;
  logic                      armed;
  logic                      fin_rise;
  logic [31:0]               capture;
  logic [3:0]                byte_idx;
  logic [2:0]                bit_idx;
  logic [BAUD_W-1:0]         baud_cnt;
  logic                      baud_wrap;
  logic [BLINK_DIV_BITS-1:0] blink_cnt;
  logic [7:0]                tx_byte;
  logic                      tx_d, busy_d, done_d, led_d;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // armed stays low until i_finished has been seen low once after reset,
  // so a level that is already high when reset releases does not trigger.
  assign fin_rise  = i_finished & ~fin_q & armed;
  assign baud_wrap = (baud_cnt == BAUD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      fin_q     <= 1'b0;
      armed     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      state     <= state_nxt;
      fin_q     <= i_finished;
      armed     <= armed | ~i_finished;
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      capture  <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else begin
      if (state == S_IDLE || state == S_DONE) baud_cnt <= '0;
      else if (baud_wrap)                     baud_cnt <= '0;
      else                                    baud_cnt <= baud_cnt + 1'b1;

      if (state == S_IDLE && fin_rise) begin
        capture  <= i_result;
        byte_idx <= '0;
        bit_idx  <= '0;
      end
      if (state == S_DATA && baud_wrap) bit_idx <= bit_idx + 3'd1;
      if (state == S_STOP && baud_wrap && byte_idx < LAST_BYTE) byte_idx <= byte_idx + 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (fin_rise) state_nxt = S_START;
      S_START: if (baud_wrap) state_nxt = S_DATA;
`ifdef REPORTER_PARITY_EN
      S_DATA:   if (baud_wrap && bit_idx == 3'd7) state_nxt = S_PARITY;
      S_PARITY: if (baud_wrap) state_nxt = S_STOP;
`else
      S_DATA:   if (baud_wrap && bit_idx == 3'd7) state_nxt = S_STOP;
`endif
      S_STOP:  if (baud_wrap) state_nxt = (byte_idx < LAST_BYTE) ? S_START : S_DONE;
      S_DONE:  if (!i_finished) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_byte = 8'h0A;
    case (byte_idx)
      4'd0:    tx_byte = 8'h30;
      4'd1:    tx_byte = 8'h78;
      4'd2:    tx_byte = hex_ascii(capture[31:28]);
      4'd3:    tx_byte = hex_ascii(capture[27:24]);
      4'd4:    tx_byte = hex_ascii(capture[23:20]);
      4'd5:    tx_byte = hex_ascii(capture[19:16]);
      4'd6:    tx_byte = hex_ascii(capture[15:12]);
      4'd7:    tx_byte = hex_ascii(capture[11:8]);
      4'd8:    tx_byte = hex_ascii(capture[7:4]);
      4'd9:    tx_byte = hex_ascii(capture[3:0]);
      4'd10:   tx_byte = 8'h0D;
      default: tx_byte = 8'h0A;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    done_d = 1'b0;
    led_d  = 1'b0;
    case (state)
      S_START: begin tx_d = 1'b0;             busy_d = 1'b1; end
      S_DATA:  begin tx_d = tx_byte[bit_idx]; busy_d = 1'b1; end
`ifdef REPORTER_PARITY_EN
      S_PARITY: begin tx_d = ^tx_byte;        busy_d = 1'b1; end
`endif
      S_STOP:  busy_d = 1'b1;
      S_DONE:  begin done_d = 1'b1; led_d = blink_cnt[BLINK_DIV_BITS-1]; end
      default: ;
    endcase
  end

  // Outputs are registered, so the line lags the state by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_uart_tx <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_led     <= 1'b0;
    end else begin
      o_uart_tx <= tx_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
      o_led     <= led_d;
    end
  end

endmodule

// File: tb/tb_result_uart_reporter.sv
// Directed bench for result_uart_reporter: a UART decoder checks bytes against a queue of expected bytes.
module tb_result_uart_reporter;

  localparam int CPB = 4;
`ifdef REPORTER_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int EXP_BUSY = 12 * FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        finished;
  logic [31:0] result;
  logic        tx, busy, done, led;

  int vectors = 0;
  int miscompares = 0;
  int rx_count = 0;
  logic [7:0] exp_q[$];

  logic [7:0] msg1 [12] = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h32, 8'h41, 8'h0D, 8'h0A};
  logic [7:0] msg2 [12] = '{8'h30, 8'h78, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};

  result_uart_reporter #(.CLKS_PER_BIT(CPB), .BLINK_DIV_BITS(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_finished(finished), .i_result(result),
    .o_uart_tx(tx), .o_busy(busy), .o_done(done), .o_led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ascii_hex(input logic [3:0] n);
    return (n < 10) ? (8'd48 + 8'(n)) : (8'd65 + 8'(n) - 8'd10);
  endfunction

  task automatic push_model(input logic [31:0] v);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
    for (int i = 7; i >= 0; i--) exp_q.push_back(ascii_hex(v[i*4 +: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Decoder: samples each bit near its middle; frames overlapping a reset are dropped.
  logic [7:0] rx_b;
  logic       rx_start, rx_par, rx_stop, rx_abort;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        rx_abort = 1'b0;
        repeat (2) begin @(negedge clk); if (rst_n !== 1'b1) rx_abort = 1'b1; end
        rx_start = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) begin @(negedge clk); if (rst_n !== 1'b1) rx_abort = 1'b1; end
          rx_b[i] = tx;
        end
`ifdef REPORTER_PARITY_EN
        repeat (CPB) begin @(negedge clk); if (rst_n !== 1'b1) rx_abort = 1'b1; end
        rx_par = tx;
`else
        rx_par = ^rx_b;
`endif
        repeat (CPB) begin @(negedge clk); if (rst_n !== 1'b1) rx_abort = 1'b1; end
        rx_stop = tx;
        if (!rx_abort) begin
          check("rx_start_bit", {31'h0, rx_start}, 32'h0);
          check("rx_stop_bit", {31'h0, rx_stop}, 32'h1);
          check("rx_parity", {31'h0, rx_par}, {31'h0, ^rx_b});
          if (exp_q.size() == 0) check("rx_unexpected_byte", {24'h0, rx_b}, 32'h100);
          else check("rx_byte", {24'h0, rx_b}, {24'h0, exp_q.pop_front()});
          rx_count++;
        end
      end
    end
  end

  // Called right after i_finished is raised at a negedge.
  // mode 1: change result and pulse finished mid-message; mode 2: drop finished mid-message.
  task automatic run_msg(input int mode);
    int cnt;
    logic led_bad;
    @(posedge clk); #1;
    check("tx_before_edge", {31'h0, tx}, 32'h1);
    @(posedge clk); #1;
    check("tx_start_latency", {31'h0, tx}, 32'h0);
    check("busy_rise", {31'h0, busy}, 32'h1);
    cnt = 1;
    led_bad = 1'b0;
    for (int c = 1; c < 2000; c++) begin
      if (led !== 1'b0) led_bad = 1'b1;
      @(posedge clk); #1;
      if (mode == 1 && c == 100) result = 32'h0;
      if (mode == 1 && c == 200) finished = 1'b0;
      if (mode == 1 && c == 201) finished = 1'b1;
      if (mode == 2 && c == 50)  finished = 1'b0;
      if (busy !== 1'b1) break;
      cnt++;
    end
    check("busy_cycles", cnt, EXP_BUSY);
    check("led_off_busy", {31'h0, led_bad}, 32'h0);
    check("done_after_busy", {31'h0, done}, 32'h1);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
    check("rx_drain", exp_q.size(), 0);
  endtask

  initial begin
    int rx_before, busy_seen, prev, last, nchg, bad;
    rst_n = 1'b0; finished = 1'b0; result = '0;
    #12;
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_led", {31'h0, led}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Message 1: 0x0000002A, then LED blink while in DONE
    result = 32'h0000_002A;
    foreach (msg1[i]) exp_q.push_back(msg1[i]);
    finished = 1'b1;
    run_msg(0);
    wait_drain();
    prev = led; last = -1; nchg = 0; bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (led !== prev[0]) begin
        if (last >= 0 && c - last != 8) bad++;
        last = c; nchg++; prev = led;
      end
    end
    check("led_toggle_count_ge4", {31'h0, nchg >= 4}, 32'h1);
    check("led_period", bad, 0);
    check("done_held", {31'h0, done}, 32'h1);

    @(negedge clk); finished = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("done_clear", {31'h0, done}, 32'h0);
    check("idle_led", {31'h0, led}, 32'h0);

    // Message 2: 0xDEADBEEF, result cleared and finished pulsed mid-message
    @(negedge clk);
    result = 32'hDEAD_BEEF;
    foreach (msg2[i]) exp_q.push_back(msg2[i]);
    finished = 1'b1;
    run_msg(1);
    wait_drain();
    rx_before = rx_count; busy_seen = 0;
    repeat (100) begin @(posedge clk); #1; if (busy !== 1'b0) busy_seen++; end
    check("no_retrigger_busy", busy_seen, 0);
    check("no_retrigger_rx", rx_count, rx_before);
    check("done_stays", {31'h0, done}, 32'h1);
    @(negedge clk); finished = 1'b0;
    repeat (3) @(negedge clk);

    // Message 3: finished drops while busy -> one-cycle done pulse, then idle
    result = 32'h0000_0007;
    push_model(32'h0000_0007);
    finished = 1'b1;
    run_msg(2);
    @(posedge clk); #1;
    check("done_pulse_end", {31'h0, done}, 32'h0);
    wait_drain();
    repeat (3) @(negedge clk);

    // Message 4: reset during byte 3 data bits, release with finished high
    result = 32'h1234_ABCD;
    push_model(32'h1234_ABCD);
    finished = 1'b1;
    repeat (131) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", {31'h0, tx}, 32'h1);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    check("rx_before_abort", rx_count, 3 + 36);
    exp_q.delete();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    rx_before = rx_count; busy_seen = 0;
    repeat (100) begin @(posedge clk); #1; if (busy !== 1'b0 || tx !== 1'b1) busy_seen++; end
    check("no_tx_after_rst", busy_seen, 0);
    check("no_rx_after_rst", rx_count, rx_before);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
